loop_iv_gen: RTL and testbench

Nested-loop induction-variable generator for one MAGE access unit. It walks a loop nest of up to `N_LOOPS` levels and emits one IV tuple per handshake. It also routes the IVs into the `[N_SUBSCRIPTS][N_IV_PER_SUBSCRIPT]` layout consumed by the subscript-generation stage, which multiplies them by strides and sums them into flat subscripts. Sequencing is a small FSM with valid/ready back-pressure, so the downstream address path can stall the nest.

---
 rtl/loop_iv_gen.sv | 182 ++++++++++++++++++
 tb/tb_loop_iv_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_iv_gen.sv
// Nested-loop induction-variable generator with valid/ready output and IV-to-subscript routing.
// Optional accepted-tuple counter: define MAGE_IV_GEN_ITER_CNT_EN to build it.
package mage_pkg;
  localparam int NBIT_LP_IV         = 8;
  localparam int N_SUBSCRIPTS       = 2;
  localparam int N_IV_PER_SUBSCRIPT = 2;
endpackage

module loop_iv_gen #(
  parameter int N_LOOPS            = 4,
  parameter int NBIT_LP_IV         = mage_pkg::NBIT_LP_IV,
  parameter int N_SUBSCRIPTS       = mage_pkg::N_SUBSCRIPTS,
  parameter int N_IV_PER_SUBSCRIPT = mage_pkg::N_IV_PER_SUBSCRIPT,
  localparam int SELW              = $clog2(N_LOOPS + 1)
) (
  input  logic                                             clk_i,
  input  logic                                             rst_n_i,
  input  logic                                             start_i,
  input  logic                                             abort_i,
  input  logic [N_LOOPS*NBIT_LP_IV-1:0]                    lb_i,
  input  logic [N_LOOPS*NBIT_LP_IV-1:0]                    ub_i,
  input  logic [N_LOOPS*NBIT_LP_IV-1:0]                    step_i,
  input  logic [N_SUBSCRIPTS*N_IV_PER_SUBSCRIPT*SELW-1:0]  iv_sel_i,
  input  logic                                             ready_i,
  output logic                                             valid_o,
  output logic [N_LOOPS*NBIT_LP_IV-1:0]                    iv_o,
  output logic [N_SUBSCRIPTS*N_IV_PER_SUBSCRIPT*NBIT_LP_IV-1:0] iv_sub_o,
  output logic                                             last_o,
  output logic                                             busy_o,
  output logic                                             done_o,
  output logic [31:0]                                      iter_cnt_o
);

  localparam int IDXW = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1;
  localparam logic [SELW-1:0] SEL_ZERO = SELW'(N_LOOPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] r_lb;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] r_ub;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] r_step;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] r_iv;
  logic [N_SUBSCRIPTS-1:0][N_IV_PER_SUBSCRIPT-1:0][SELW-1:0] r_sel;
  logic r_valid;
  logic r_done;

  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] w_lb_in;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] w_ub_in;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] w_step_in;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] w_step_eff;
  logic [N_LOOPS-1:0][NBIT_LP_IV-1:0] w_iv_next;
  logic [N_LOOPS-1:0]                 w_nonempty;
  logic [N_LOOPS-1:0]                 w_wrap;
  logic [N_LOOPS:0]                   w_carry;
  logic [N_SUBSCRIPTS-1:0][N_IV_PER_SUBSCRIPT-1:0][NBIT_LP_IV-1:0] w_sub;
  logic w_last;
  logic w_start_ok;

  assign w_lb_in   = lb_i;
  assign w_ub_in   = ub_i;
  assign w_step_in = step_i;
  assign w_carry[0] = 1'b1;

  // Odometer: each level wraps to lb when iv+step reaches ub; the extra sum bit
  // keeps a near-max ub from looking like "not yet reached" after overflow.
  for (genvar gi = 0; gi < N_LOOPS; gi++) begin : g_level
    logic [NBIT_LP_IV:0] w_sum;
    assign w_nonempty[gi] = w_lb_in[gi] < w_ub_in[gi];
    assign w_step_eff[gi] = (w_step_in[gi] == '0) ? NBIT_LP_IV'(1) : w_step_in[gi];
    assign w_sum          = {1'b0, r_iv[gi]} + {1'b0, r_step[gi]};
    assign w_wrap[gi]     = w_sum >= {1'b0, r_ub[gi]};
    assign w_carry[gi+1]  = w_carry[gi] & w_wrap[gi];
    assign w_iv_next[gi]  = !w_carry[gi] ? r_iv[gi] :
                            (w_wrap[gi] ? r_lb[gi] : w_sum[NBIT_LP_IV-1:0]);
  end

  // Carry out of the top level means the current tuple is the final one.
  assign w_last = w_carry[N_LOOPS];

  for (genvar gi = 0; gi < N_SUBSCRIPTS; gi++) begin : g_sub
    for (genvar gk = 0; gk < N_IV_PER_SUBSCRIPT; gk++) begin : g_slot
      logic [SELW-1:0] w_sel;
      assign w_sel = r_sel[gi][gk];
      assign w_sub[gi][gk] = (w_sel < SEL_ZERO) ? r_iv[w_sel[IDXW-1:0]] : '0;
    end
  end

  assign w_start_ok = start_i & ~abort_i & (r_state == S_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_lb    <= '0;
      r_ub    <= '0;
      r_step  <= '0;
      r_iv    <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_lb   <= w_lb_in;
            r_ub   <= w_ub_in;
            r_step <= w_step_eff;
            r_sel  <= iv_sel_i;
            r_iv   <= w_lb_in;
            if (&w_nonempty) begin
              r_state <= S_RUN;
              r_valid <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (r_valid && ready_i) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_iv <= w_iv_next;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAGE_IV_GEN_ITER_CNT_EN
  logic [31:0] r_iter_cnt;
  logic        w_fire_acc;

  assign w_fire_acc = r_valid & ready_i & ~abort_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_iter_cnt <= '0;
    end else if (w_start_ok) begin
      r_iter_cnt <= '0;
    end else if (w_fire_acc && (r_iter_cnt != '1)) begin
      r_iter_cnt <= r_iter_cnt + 32'd1;
    end
  end

  assign iter_cnt_o = r_iter_cnt;
`else
  logic w_start_unused;
  assign w_start_unused = w_start_ok;
  assign iter_cnt_o = '0;
`endif

  assign valid_o  = r_valid;
  assign iv_o     = r_iv;
  assign iv_sub_o = w_sub;
  assign last_o   = r_valid & w_last;
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = r_done;

endmodule

// File: tb/tb_loop_iv_gen.sv
// Table-driven bench for loop_iv_gen: expected tuples queued at start, popped on each fire.
`timescale 1ns/1ps
module tb_loop_iv_gen;
  localparam int NL = 4;
  localparam int NB = 8;
  localparam int NS = 2;
  localparam int NK = 2;
  localparam int SW = 3;
`ifdef MAGE_IV_GEN_ITER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_n_i, start_i, abort_i, ready_i;
  logic [NL*NB-1:0] lb_i, ub_i, step_i, iv_o;
  logic [NS*NK*SW-1:0] iv_sel_i;
  logic [NS*NK*NB-1:0] iv_sub_o;
  logic valid_o, last_o, busy_o, done_o;
  logic [31:0] iter_cnt_o;

  always #5 clk_i = ~clk_i;

  loop_iv_gen #(
    .N_LOOPS(NL), .NBIT_LP_IV(NB), .N_SUBSCRIPTS(NS), .N_IV_PER_SUBSCRIPT(NK)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .lb_i(lb_i), .ub_i(ub_i), .step_i(step_i), .iv_sel_i(iv_sel_i),
    .ready_i(ready_i), .valid_o(valid_o), .iv_o(iv_o), .iv_sub_o(iv_sub_o),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .iter_cnt_o(iter_cnt_o)
  );

  typedef struct packed {
    logic [NL-1:0][NB-1:0] lb;
    logic [NL-1:0][NB-1:0] ub;
    logic [NL-1:0][NB-1:0] step;
    logic [NS*NK-1:0][SW-1:0] sel;
    logic [1:0] mode;    // 0: ready always, 1: random ready, 2: 3-cycle stall after 2 fires
    logic       poke;    // pulse start_i while running
    logic [15:0] n_exp;  // hand-derived tuple count
  } vec_t;

  typedef struct packed {
    logic [NL-1:0][NB-1:0] iv;
    logic last;
  } tup_t;

  tup_t exp_q[$];
  vec_t vecs[7];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] lb, input logic [31:0] ub,
                              input logic [31:0] step, input logic [11:0] sel,
                              input logic [1:0] mode, input logic poke, input int n);
    vec_t v;
    v.lb = lb; v.ub = ub; v.step = step; v.sel = sel;
    v.mode = mode; v.poke = poke; v.n_exp = 16'(n);
    return v;
  endfunction

  function automatic logic [NS*NK*NB-1:0] route(input logic [NL-1:0][NB-1:0] iv,
                                                input logic [NS*NK-1:0][SW-1:0] sel);
    logic [NS*NK-1:0][NB-1:0] r;
    int s;
    for (int j = 0; j < NS*NK; j++) begin
      s = int'(sel[j]);
      if (s < NL) r[j] = iv[s[1:0]];
      else        r[j] = '0;
    end
    return r;
  endfunction

  // Mixed-radix enumeration: tuple i has digit d_l at level l, iv = lb + d*step.
  task automatic build(input vec_t v);
    int n[NL];
    int st[NL];
    int total, r, d;
    tup_t t;
    exp_q.delete();
    total = 1;
    for (int l = 0; l < NL; l++) begin
      st[l] = (v.step[l] == 0) ? 1 : int'(v.step[l]);
      if (v.ub[l] <= v.lb[l]) n[l] = 0;
      else n[l] = (int'(v.ub[l]) - int'(v.lb[l]) + st[l] - 1) / st[l];
      total = total * n[l];
    end
    for (int i = 0; i < total; i++) begin
      r = i;
      for (int l = 0; l < NL; l++) begin
        d = r % n[l];
        r = r / n[l];
        t.iv[l] = NB'(int'(v.lb[l]) + d * st[l]);
      end
      t.last = (i == total - 1);
      exp_q.push_back(t);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int fires, cyc, stall, last_fire;
    bit done_seen, held;
    logic [NL*NB-1:0] h_iv;
    logic [NS*NK*NB-1:0] h_sub;
    logic h_last;
    tup_t t;
    build(v);
    lb_i = v.lb; ub_i = v.ub; step_i = v.step; iv_sel_i = v.sel;
    abort_i = 1'b0; ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lb_i = $urandom; ub_i = $urandom; step_i = $urandom; iv_sel_i = 12'($urandom);
    chk($sformatf("v%0d first_valid", idx), 64'(valid_o), 64'(v.n_exp != 0));
    fires = 0; cyc = 0; stall = 0; last_fire = -1; done_seen = 0; held = 0;
    h_iv = '0; h_sub = '0; h_last = 1'b0;
    while (!done_seen && cyc < 500) begin
      if (done_o) begin
        done_seen = 1;
        chk($sformatf("v%0d done_valid", idx), 64'(valid_o), 64'd0);
        chk($sformatf("v%0d done_cycle", idx), 64'(cyc), 64'(last_fire + 1));
      end else begin
        if (held) begin
          chk($sformatf("v%0d hold_iv", idx), 64'(iv_o), 64'(h_iv));
          chk($sformatf("v%0d hold_sub", idx), 64'(iv_sub_o), 64'(h_sub));
          chk($sformatf("v%0d hold_last", idx), 64'(last_o), 64'(h_last));
        end
        case (v.mode)
          2'd1:    ready_i = ($urandom_range(0, 2) != 0);
          2'd2:    ready_i = !(fires == 2 && stall < 3);
          default: ready_i = 1'b1;
        endcase
        if (!ready_i) stall++;
        if (v.poke && cyc == 1) start_i = 1'b1;
        held = 0;
        if (valid_o) begin
          if (ready_i) begin
            if (exp_q.size() == 0) begin
              chk($sformatf("v%0d extra_tuple", idx), 64'(iv_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
              t = exp_q.pop_front();
              chk($sformatf("v%0d t%0d iv", idx, fires), 64'(iv_o), 64'(t.iv));
              chk($sformatf("v%0d t%0d sub", idx, fires), 64'(iv_sub_o), 64'(route(t.iv, v.sel)));
              chk($sformatf("v%0d t%0d last", idx, fires), 64'(last_o), 64'(t.last));
            end
            fires++;
            last_fire = cyc;
          end else begin
            held = 1; h_iv = iv_o; h_sub = iv_sub_o; h_last = last_o;
          end
        end
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cyc++;
      end
    end
    chk($sformatf("v%0d done_seen", idx), 64'(done_seen), 64'd1);
    chk($sformatf("v%0d n_fires", idx), 64'(fires), 64'(v.n_exp));
    chk($sformatf("v%0d q_left", idx), 64'(exp_q.size()), 64'd0);
    chk($sformatf("v%0d iter_cnt", idx), 64'(iter_cnt_o), CNT_EN ? 64'(v.n_exp) : 64'd0);
    @(posedge clk_i); #1;
    chk($sformatf("v%0d idle_busy", idx), 64'(busy_o), 64'd0);
    chk($sformatf("v%0d idle_done", idx), 64'(done_o), 64'd0);
    $display("[TB] vector %0d: %0d tuples in %0d cycles", idx, fires, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h00000000, 32'h01010203, 32'h01010101, {3'd4, 3'd2, 3'd1, 3'd0}, 2'd0, 1'b0, 6);
    vecs[1] = mk(32'h00000002, 32'h01010209, 32'h01010103, {3'd3, 3'd2, 3'd1, 3'd0}, 2'd0, 1'b1, 6);
    vecs[2] = mk(32'h00000064, 32'h010101FF, 32'h010101C8, {3'd4, 3'd4, 3'd4, 3'd0}, 2'd0, 1'b0, 1);
    vecs[3] = mk(32'h00000400, 32'h01010401, 32'h01010101, {3'd1, 3'd0, 3'd1, 3'd0}, 2'd0, 1'b0, 0);
    vecs[4] = mk(32'h00050001, 32'h0A070307, 32'h04010002, {3'd0, 3'd1, 3'd2, 3'd3}, 2'd1, 1'b0, 54);
    vecs[5] = mk(32'h00000000, 32'h010101FA, 32'h01010132, {3'd3, 3'd0, 3'd4, 3'd4}, 2'd1, 1'b0, 5);
    vecs[6] = mk(32'h00000000, 32'h01010203, 32'h01010101, {3'd4, 3'd2, 3'd1, 3'd0}, 2'd2, 1'b0, 6);

    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
    lb_i = '0; ub_i = '0; step_i = '0; iv_sel_i = '0;
    #1;
    chk("rst valid", 64'(valid_o), 64'd0);
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst last", 64'(last_o), 64'd0);
    chk("rst iv", 64'(iv_o), 64'd0);
    chk("rst sub", 64'(iv_sub_o), 64'd0);
    chk("rst cnt", 64'(iter_cnt_o), 64'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort while a tuple is firing: no done, tuple not counted, restart from lb.
    lb_i = vecs[0].lb; ub_i = vecs[0].ub; step_i = vecs[0].step; iv_sel_i = vecs[0].sel;
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("abort pre_valid", 64'(valid_o), 64'd1);
    chk("abort pre_iv", 64'(iv_o), 64'h0000_0002);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk("abort valid", 64'(valid_o), 64'd0);
    chk("abort busy", 64'(busy_o), 64'd0);
    chk("abort done", 64'(done_o), 64'd0);
    chk("abort cnt", 64'(iter_cnt_o), CNT_EN ? 64'd2 : 64'd0);
    @(posedge clk_i); #1;
    chk("abort done2", 64'(done_o), 64'd0);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("restart valid", 64'(valid_o), 64'd1);
    chk("restart iv", 64'(iv_o), 64'h0000_0000);
    chk("restart cnt", 64'(iter_cnt_o), 64'd0);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    $display("[TB] abort sequence complete");

    // Asynchronous reset in the middle of a run.
    lb_i = vecs[4].lb; ub_i = vecs[4].ub; step_i = vecs[4].step; iv_sel_i = vecs[4].sel;
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #3;
    rst_n_i = 1'b0;
    #1;
    chk("arst valid", 64'(valid_o), 64'd0);
    chk("arst busy", 64'(busy_o), 64'd0);
    chk("arst iv", 64'(iv_o), 64'd0);
    chk("arst last", 64'(last_o), 64'd0);
    chk("arst sub", 64'(iv_sub_o), 64'd0);
    chk("arst cnt", 64'(iter_cnt_o), 64'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("arst post_busy", 64'(busy_o), 64'd0);
    $display("[TB] async reset sequence complete");

    run_vec(7, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
